// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory request/acknowledge bus between the MEM stage and dmem/cache.
interface mem_access_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage load/store unit with req/ack dmem handshake and pipeline busywait.
// Optional REQ timeout with bus_error pulse is built when MEM_TIMEOUT_EN is defined.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [31:0]               addr_i,
  input  logic [31:0]               store_data_i,
  input  logic [3:0]                read_write_sel_i,
  input  logic                      is_memory_instruction_i,
  mem_access_stage_if.master        dmem,
  output logic                      busywait_o,
  output logic [31:0]               load_data_o,
  output logic                      misaligned_o,
  output logic                      bus_error_o
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] load_q, load_d;
  logic        misaligned_q, misaligned_d;
  logic        bus_error_q, bus_error_d;

  logic [2:0]  funct3_in;
  logic [1:0]  off_in;
  logic        is_byte, is_half, is_misaligned;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] rdata_shifted;
  logic [31:0] load_fmt;

  assign funct3_in     = read_write_sel_i[2:0];
  assign off_in        = addr_i[1:0];
  // funct3[1:0] encodes size; 011/110/111 fall into the word bucket.
  assign is_byte       = (funct3_in[1:0] == 2'b00);
  assign is_half       = (funct3_in[1:0] == 2'b01);
  assign is_misaligned = is_half ? off_in[0] : (!is_byte && (off_in != 2'b00));

  always_comb begin
    lane_wdata = store_data_i;
    lane_wstrb = 4'b1111;
    if (is_byte) begin
      lane_wdata = {4{store_data_i[7:0]}};
      lane_wstrb = 4'b0001 << off_in;
    end else if (is_half) begin
      lane_wdata = {2{store_data_i[15:0]}};
      lane_wstrb = 4'b0011 << off_in;
    end
  end

  assign rdata_shifted = dmem.rdata >> {off_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  load_fmt = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_fmt = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b100:  load_fmt = {24'd0, rdata_shifted[7:0]};
      3'b101:  load_fmt = {16'd0, rdata_shifted[15:0]};
      default: load_fmt = dmem.rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^(16'(TIMEOUT_CYCLES));
`endif

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
    load_d       = load_q;
    misaligned_d = 1'b0;
    bus_error_d  = 1'b0;
    busywait_o   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (is_memory_instruction_i) begin
          if (is_misaligned) begin
            misaligned_d = 1'b1;
          end else begin
            busywait_o = 1'b1;
            state_d    = REQ;
            req_d      = 1'b1;
            we_d       = read_write_sel_i[3];
            addr_d     = {addr_i[31:2], 2'b00};
            wdata_d    = lane_wdata;
            wstrb_d    = read_write_sel_i[3] ? lane_wstrb : 4'b0000;
            funct3_d   = funct3_in;
            off_d      = off_in;
`ifdef MEM_TIMEOUT_EN
            cnt_d      = 16'd0;
`endif
          end
        end
      end
      REQ: begin
        busywait_o = 1'b1;
        if (dmem.ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) load_d = load_fmt;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LIMIT) begin
          req_d       = 1'b0;
          bus_error_d = 1'b1;
          state_d     = DONE;
          if (!we_q) load_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Keep upstream released while reset is held, whatever state we are leaving.
    if (rst_i) busywait_o = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      wstrb_q      <= 4'd0;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
      load_q       <= 32'd0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      load_q       <= load_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign dmem.req     = req_q;
  assign dmem.we      = we_q;
  assign dmem.addr    = addr_q;
  assign dmem.wdata   = wdata_q;
  assign dmem.wstrb   = wstrb_q;
  assign load_data_o  = load_q;
  assign misaligned_o = misaligned_q;
`ifdef MEM_TIMEOUT_EN
  assign bus_error_o  = bus_error_q;
`else
  assign bus_error_o  = 1'b0;
  logic unused_bus_error;
  assign unused_bus_error = bus_error_q ^ bus_error_d;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized + directed bench for mem_access_stage against a word-memory model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic [3:0]  rw_sel;
  logic        is_mem;
  logic        busywait;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_error;

  mem_access_stage_if dmem_bus ();

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .addr_i                  (addr_i),
    .store_data_i            (store_data_i),
    .read_write_sel_i        (rw_sel),
    .is_memory_instruction_i (is_mem),
    .dmem                    (dmem_bus),
    .busywait_o              (busywait),
    .load_data_o             (load_data),
    .misaligned_o            (misaligned),
    .bus_error_o             (bus_error)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem [0:15];
  logic [31:0] exp_load = 32'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % 16);
  endfunction

  // Called just after a rising edge with the DUT in IDLE; returns in the same phase, DUT in IDLE.
  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int waits, input bit junk_ack);
    int          size, o;
    logic [31:0] e_wdata, e_w, b;
    logic [3:0]  e_wstrb;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    o    = int'(a % 4);
    rw_sel = {st, f3}; addr_i = a; store_data_i = sd; is_mem = 1'b1;
    if (a % size != 0) begin
      @(negedge clk);
      check_val("mis_busy", 32'(busywait), 32'd0);
      @(posedge clk); #1; is_mem = 1'b0;
      @(negedge clk);
      check_val("mis_pulse", 32'(misaligned), 32'd1);
      check_val("mis_req", 32'(dmem_bus.req), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check_val("mis_once", 32'(misaligned), 32'd0);
      @(posedge clk); #1;
      return;
    end
    if (size == 1) begin
      e_wdata = sd[7:0] * 32'h0101_0101;  e_wstrb = 4'(1 << o);
    end else if (size == 2) begin
      e_wdata = sd[15:0] * 32'h0001_0001; e_wstrb = 4'(3 << o);
    end else begin
      e_wdata = sd; e_wstrb = 4'hF;
    end
    if (!st) e_wstrb = 4'h0;
    @(negedge clk);
    check_val("idle_busy", 32'(busywait), 32'd1);
    check_val("idle_req", 32'(dmem_bus.req), 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      check_val("req_valid", 32'(dmem_bus.req), 32'd1);
      check_val("req_busy", 32'(busywait), 32'd1);
      check_val("req_addr", dmem_bus.addr, a - 32'(o));
      check_val("req_we", 32'(dmem_bus.we), 32'(st));
      check_val("req_wstrb", 32'(dmem_bus.wstrb), 32'(e_wstrb));
      if (st) check_val("req_wdata", dmem_bus.wdata, e_wdata);
      if (k == waits) begin
        dmem_bus.ack = 1'b1; dmem_bus.rdata = mem[widx(a)];
      end
      @(posedge clk); #1;
      dmem_bus.ack = 1'b0; dmem_bus.rdata = $urandom;
    end
    if (st) begin
      for (int i = 0; i < 4; i++)
        if (e_wstrb[i]) mem[widx(a)][8*i +: 8] = e_wdata[8*i +: 8];
    end else begin
      e_w = mem[widx(a)];
      case (f3)
        3'b000: begin b = (e_w >> (8*o)) % 256;   exp_load = (b >= 128)   ? b + 32'hFFFF_FF00 : b; end
        3'b001: begin b = (e_w >> (8*o)) % 65536; exp_load = (b >= 32768) ? b + 32'hFFFF_0000 : b; end
        3'b100: exp_load = (e_w >> (8*o)) % 256;
        3'b101: exp_load = (e_w >> (8*o)) % 65536;
        default: exp_load = e_w;
      endcase
    end
    @(negedge clk);
    check_val("done_busy", 32'(busywait), 32'd0);
    check_val("done_req", 32'(dmem_bus.req), 32'd0);
    check_val("done_load", load_data, exp_load);
    check_val("done_buserr", 32'(bus_error), 32'd0);
    check_val("done_mis", 32'(misaligned), 32'd0);
    if (junk_ack) begin
      dmem_bus.ack = 1'b1; dmem_bus.rdata = $urandom;
    end
    @(posedge clk); #1;
    dmem_bus.ack = 1'b0; is_mem = 1'b0;
    if (junk_ack) begin
      @(negedge clk);
      check_val("junk_ack_load", load_data, exp_load);
      check_val("junk_ack_req", 32'(dmem_bus.req), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; is_mem = 1'b0; addr_i = '0; store_data_i = '0; rw_sel = '0;
    dmem_bus.ack = 1'b0; dmem_bus.rdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_req", 32'(dmem_bus.req), 32'd0);
    check_val("rst_busy", 32'(busywait), 32'd0);
    check_val("rst_addr", dmem_bus.addr, 32'd0);
    check_val("rst_wstrb", 32'(dmem_bus.wstrb), 32'd0);
    check_val("rst_load", load_data, 32'd0);
    check_val("rst_mis", 32'(misaligned), 32'd0);
    @(posedge clk); #1;

    access(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 1'b0);
    mem[widx(32'h203)] = 32'h80FF_1234;
    access(1'b0, 3'b000, 32'h203, 32'h0, 2, 1'b0);
    check_val("lb_0x203", exp_load, 32'hFFFF_FF80);
    mem[widx(32'h302)] = 32'hBEEF_0000;
    access(1'b0, 3'b101, 32'h302, 32'h0, 1, 1'b1);
    check_val("lhu_0x302", load_data, 32'h0000_BEEF);
    access(1'b1, 3'b000, 32'h301, 32'h0000_00AB, 0, 1'b0);
    access(1'b0, 3'b010, 32'h102, 32'h0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      bit          st;
      logic [2:0]  f3;
      st = 1'($urandom_range(0, 1));
      f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      access(st, f3, 32'h200 + 32'($urandom_range(0, 63)), $urandom,
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset while a load sits in REQ without ack.
    rw_sel = 4'b0010; addr_i = 32'h208; is_mem = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("pre_rst_req", 32'(dmem_bus.req), 32'd1);
    @(posedge clk); #1; rst = 1'b1; is_mem = 1'b0;
    @(negedge clk);
    check_val("in_rst_busy", 32'(busywait), 32'd0);
    @(posedge clk); #1; rst = 1'b0; exp_load = 32'd0;
    @(negedge clk);
    check_val("post_rst_req", 32'(dmem_bus.req), 32'd0);
    check_val("post_rst_busy", 32'(busywait), 32'd0);
    check_val("post_rst_addr", dmem_bus.addr, 32'd0);
    check_val("post_rst_wdata", dmem_bus.wdata, 32'd0);
    check_val("post_rst_we", 32'(dmem_bus.we), 32'd0);
    check_val("post_rst_load", load_data, 32'd0);
    @(posedge clk); #1;
    access(1'b0, 3'b010, 32'h20C, 32'h0, 0, 1'b0);

`ifdef MEM_TIMEOUT_EN
    rw_sel = 4'b0010; addr_i = 32'h210; is_mem = 1'b1;
    @(negedge clk);
    check_val("to_idle_busy", 32'(busywait), 32'd1);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("to_req", 32'(dmem_bus.req), 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_val("to_buserr", 32'(bus_error), 32'd1);
    check_val("to_load", load_data, 32'd0);
    check_val("to_busy", 32'(busywait), 32'd0);
    check_val("to_req_drop", 32'(dmem_bus.req), 32'd0);
    @(posedge clk); #1; is_mem = 1'b0;
    @(negedge clk);
    check_val("to_buserr_once", 32'(bus_error), 32'd0);
    @(posedge clk); #1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-stage access unit, directly downstream of the EX/MEM pipeline register.
- Consumes the address (ALU result), store data (rs2), access type and memory-instruction flag, and runs a request/acknowledge transaction to the data memory/cache.
- Returns formatted load data toward MEM/WB.
- Drives busywait to freeze upstream pipeline registers while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles REQ may wait for ack (used only with MEM_TIMEOUT_EN); range 1..65535

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- addr_i  in  32  byte address (EX/MEM ALU output)
- store_data_i  in  32  rs2 value to store
- read_write_sel_i  in  4  [3]=1 store / 0 load; [2:0]=funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- is_memory_instruction_i  in  1  current MEM-stage instruction accesses memory
- dmem_req_o  out  1  request valid, held until ack
- dmem_we_o  out  1  1=write
- dmem_addr_o  out  32  word-aligned address ({addr_i[31:2],2'b00})
- dmem_wdata_o  out  32  store data lane-shifted
- dmem_wstrb_o  out  4  byte strobes (0000 on reads)
- dmem_ack_i  in  1  memory completes transaction
- dmem_rdata_i  in  32  read word, valid with ack
- busywait_o  out  1  stall upstream registers
- load_data_o  out  32  formatted load result, registered
- misaligned_o  out  1  one-cycle pulse on misaligned access
- bus_error_o  out  1  one-cycle pulse on timeout (MEM_TIMEOUT_EN only; else tied 0)

Behaviour:
- Reset: state=IDLE; dmem_req_o=0, dmem_we_o=0, dmem_addr_o=0, dmem_wdata_o=0, dmem_wstrb_o=0, load_data_o=0, misaligned_o=0, bus_error_o=0; busywait_o=0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If is_memory_instruction_i and aligned: busywait_o=1 combinationally in the same cycle; latch addr, wdata, wstrb and we into request registers; next state REQ.
  - If misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0): no request, busywait_o=0; misaligned_o pulses the next cycle; stay IDLE.
  - Otherwise busywait_o=0.
- REQ:
  - dmem_req_o=1 and busywait_o=1; request outputs stable until ack.
  - On dmem_ack_i: if load, capture the formatted dmem_rdata_i into load_data_o; go DONE.
  - Ack in the first REQ cycle is legal: zero wait states.
- DONE:
  - busywait_o=0 and dmem_req_o=0, so upstream advances at this edge; next state IDLE.
  - load_data_o holds its value until the next captured load.
- Minimum occupancy is 3 cycles per access (IDLE detect, REQ, DONE); each ack wait state adds 1 cycle. Back-to-back memory ops: DONE -> IDLE -> REQ.
- Store lanes (o = addr[1:0]):
  - B: wdata = {4{sd[7:0]}}, wstrb = 0001<<o.
  - H: wdata = {2{sd[15:0]}}, wstrb = 0011<<o.
  - W: wdata = sd, wstrb = 1111.
- Load formatting: select byte (rdata>>(8*o)) or half (rdata>>(8*o)) from the word; sign-extend for B/H, zero-extend for BU/HU; W passes the word through.
- Unsupported funct3 (011, 110, 111): treated as W-sized, aligned check applies.
- dmem_ack_i in IDLE or DONE is ignored.
- Reset asserted in any state, including mid-REQ: next cycle IDLE with dmem_req_o=0; the outstanding transaction is abandoned.
- Stores never modify load_data_o.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - 16-bit counter cleared on entering REQ, incremented each REQ cycle without ack.
  - When count reaches TIMEOUT_CYCLES without ack: drop request, bus_error_o pulses 1 cycle, load_data_o=0, go DONE.
  - Ack in the same cycle as the limit wins (normal completion).
- MEM_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; bus_error_o constant 0.

Test Plan:
- SW addr=0x100, rs2=0xDEADBEEF, ack on first REQ cycle -> dmem_addr_o=0x100, wstrb=1111, wdata=0xDEADBEEF; busywait high exactly 2 cycles, then low in DONE.
- LB addr=0x203, rdata=0x80FF_1234, 2 wait states -> load_data_o=0xFFFFFF80; busywait high 4 cycles; dmem_req_o stable throughout.
- LHU addr=0x302, rdata=0xBEEF_0000 -> load_data_o=0x0000BEEF; then SB addr=0x301 rs2=0xAB -> wstrb=0010, wdata=0xABABABAB.
- LW addr=0x102 -> misaligned_o pulses once, dmem_req_o never asserts, busywait_o stays 0.
- Reset asserted during REQ with no ack -> next cycle dmem_req_o=0, state IDLE, all outputs at reset values.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack never given -> bus_error_o pulses after 4 REQ cycles, load_data_o=0, busywait drops in DONE.
